// File: rtl/ekf_stage_sequencer.sv
// EKF stage sequencer: host stage commands pass through a small FIFO and are
// dispatched one at a time to a downstream stage using a ready handshake.
module ekf_stage_sequencer #(
  parameter int DW     = 32,
  parameter int DEPTH  = 4,
  parameter int ANG_W  = 17,
  parameter int ANG_HI = 19,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       sys_rst,
  input  logic [2:0]                 stage_val,
  input  logic [DW-1:0]              vlr,
  input  logic [DW-1:0]              alpha,
  input  logic [DW-1:0]              rk,
  input  logic [DW-1:0]              phi,
  input  logic                       stage_rdy,
  output logic [2:0]                 out_stage,
  output logic [DW-1:0]              out_vlr,
  output logic [DW-1:0]              out_alpha,
  output logic [DW-1:0]              out_rk,
  output logic [DW-1:0]              out_phi,
  output logic [ANG_W-1:0]           out_alpha_ang,
  output logic [ANG_W-1:0]           out_phi_ang,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       cmd_drop,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [2:0]    code;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_stage_val_q;
  cmd_t             r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_cmd_drop;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [2:0]       r_out_stage;
  logic [DW-1:0]    r_out_vlr;
  logic [DW-1:0]    r_out_alpha;
  logic [DW-1:0]    r_out_rk;
  logic [DW-1:0]    r_out_phi;

  logic             w_event;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_release;
  cmd_t             w_push_cmd;
  cmd_t             w_head;

  // A command is a rising transition out of IDLE onto a valid stage code.
  assign w_event = (r_stage_val_q == 3'd0) &&
                   (stage_val >= 3'd1) && (stage_val <= 3'd4);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = w_event && (!w_full || w_pop);
  assign w_drop  = w_event && w_full && !w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  always_comb begin
    w_push_cmd.code = stage_val;
    w_push_cmd.a    = rk;
    w_push_cmd.b    = phi;
    if (stage_val == 3'd1) begin
      w_push_cmd.a = vlr;
      w_push_cmd.b = alpha;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_stage_val_q <= 3'd0;
    end else begin
      r_stage_val_q <= stage_val;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_cmd;
    end
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_cmd_drop <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_cmd_drop <= w_drop;
      if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The pop decision uses the registered count, so a push never bypasses.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (stage_rdy) begin
          w_release    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_out_stage <= 3'd0;
      r_out_vlr   <= '0;
      r_out_alpha <= '0;
      r_out_rk    <= '0;
      r_out_phi   <= '0;
    end else if (w_pop) begin
      r_out_stage <= w_head.code;
      if (w_head.code == 3'd1) begin
        r_out_vlr   <= w_head.a;
        r_out_alpha <= w_head.b;
      end else begin
        r_out_rk    <= w_head.a;
        r_out_phi   <= w_head.b;
      end
    end else if (w_release) begin
      r_out_stage <= 3'd0;
    end
  end

  assign out_stage     = r_out_stage;
  assign out_vlr       = r_out_vlr;
  assign out_alpha     = r_out_alpha;
  assign out_rk        = r_out_rk;
  assign out_phi       = r_out_phi;
  assign out_alpha_ang = {r_out_alpha[DW-1], r_out_alpha[ANG_HI -: ANG_W-1]};
  assign out_phi_ang   = {r_out_phi[DW-1], r_out_phi[ANG_HI -: ANG_W-1]};
  assign fifo_count    = r_count;
  assign cmd_drop      = r_cmd_drop;
  assign drop_cnt      = r_drop_cnt;
  assign busy          = (r_state != ST_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_ekf_stage_sequencer.sv
// Bench for ekf_stage_sequencer: directed scenarios followed by random traffic,
// all checked against a queue-based behavioural model of the command flow.
module tb_ekf_stage_sequencer;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int ANG_W = 17;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             sysRst;
   logic [2:0]       stageVal;
   logic [DW-1:0]    vlr, alpha, rk, phi;
   logic             stageRdy;
   logic [2:0]       outStage;
   logic [DW-1:0]    outVlr, outAlpha, outRk, outPhi;
   logic [ANG_W-1:0] outAlphaAng, outPhiAng;
   logic [2:0]       fifoCount;
   logic             cmdDrop;
   logic [CNT_W-1:0] dropCnt;
   logic             busy;

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   ekf_stage_sequencer #(
      .DW(DW), .DEPTH(DEPTH), .ANG_W(ANG_W), .ANG_HI(19), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .sys_rst(sysRst), .stage_val(stageVal),
      .vlr(vlr), .alpha(alpha), .rk(rk), .phi(phi), .stage_rdy(stageRdy),
      .out_stage(outStage), .out_vlr(outVlr), .out_alpha(outAlpha),
      .out_rk(outRk), .out_phi(outPhi), .out_alpha_ang(outAlphaAng),
      .out_phi_ang(outPhiAng), .fifo_count(fifoCount), .cmd_drop(cmdDrop),
      .drop_cnt(dropCnt), .busy(busy)
   );

   typedef struct {
      logic [2:0]  code;
      logic [31:0] a;
      logic [31:0] b;
   } cmdS;

   // Reference model: a queue of pending commands plus the command in flight
   cmdS         modelQ[$];
   int          mPrevSv;
   bit          mActive;
   int          mAge;
   logic [2:0]  mStage;
   logic [31:0] mVlr, mAlpha, mRk, mPhi;
   int          mDropCnt;
   bit          mDrop;

   int checks   = 0;
   int failures = 0;

   // Single comparison point; every check in the bench goes through here
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   // Sign bit on top, then bits 19..4 of the operand, by plain arithmetic
   function automatic logic [63:0] angOf(input logic [31:0] v);
      longint unsigned x;
      x = ((longint'(v) >> 31) << 16) | ((longint'(v) / 16) % 65536);
      return 64'(x);
   endfunction

   // Advance the model by one clock edge using the inputs held over that edge
   task automatic modelStep();
      bit  ev;
      int  sizeBefore;
      bit  popNow;
      cmdS c;
      if (sysRst) begin
         modelQ.delete();
         mPrevSv = 0; mActive = 0; mAge = 0; mStage = 0;
         mVlr = 0; mAlpha = 0; mRk = 0; mPhi = 0; mDropCnt = 0; mDrop = 0;
         return;
      end
      ev = (mPrevSv == 0) && (stageVal >= 1) && (stageVal <= 4);
      sizeBefore = modelQ.size();
      popNow = !mActive && (sizeBefore > 0);
      if (popNow) begin
         c = modelQ.pop_front();
         mStage = c.code;
         if (c.code == 3'd1) begin mVlr = c.a; mAlpha = c.b; end
         else begin mRk = c.a; mPhi = c.b; end
         mActive = 1; mAge = 0;
      end else if (mActive) begin
         if (mAge >= 1 && stageRdy) begin
            mActive = 0; mStage = 0;
         end else begin
            mAge = 1;
         end
      end
      mDrop = 0;
      if (ev) begin
         if (sizeBefore < DEPTH || popNow) begin
            c.code = stageVal;
            c.a = (stageVal == 3'd1) ? vlr : rk;
            c.b = (stageVal == 3'd1) ? alpha : phi;
            modelQ.push_back(c);
         end else begin
            mDrop = 1;
            if (mDropCnt < (1 << CNT_W) - 1) mDropCnt++;
         end
      end
      mPrevSv = int'(stageVal);
   endtask

   // Compare every observable output against the model
   task automatic checkAll();
      checkOutput("out_stage", outStage, mStage);
      checkOutput("out_vlr", outVlr, mVlr);
      checkOutput("out_alpha", outAlpha, mAlpha);
      checkOutput("out_rk", outRk, mRk);
      checkOutput("out_phi", outPhi, mPhi);
      checkOutput("alpha_ang", outAlphaAng, angOf(mAlpha));
      checkOutput("phi_ang", outPhiAng, angOf(mPhi));
      checkOutput("fifo_count", fifoCount, modelQ.size());
      checkOutput("cmd_drop", cmdDrop, mDrop);
      checkOutput("drop_cnt", dropCnt, mDropCnt);
      checkOutput("busy", busy, (mActive || modelQ.size() > 0));
   endtask

   // Drive one cycle of inputs at the falling edge, clock it, then check
   task automatic applyStimulus(input int sv, input logic [31:0] v,
                                input logic [31:0] al, input logic [31:0] r,
                                input logic [31:0] p, input bit rdy, input bit rst);
      stageVal = 3'(sv); vlr = v; alpha = al; rk = r; phi = p;
      stageRdy = rdy; sysRst = rst;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkAll();
   endtask

   // Directed scenarios first, then randomized traffic with occasional resets
   initial begin
      sysRst = 1; stageVal = 0; vlr = 0; alpha = 0; rk = 0; phi = 0; stageRdy = 0;
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      checkOutput("rst_stage", outStage, 0);
      checkOutput("rst_count", fifoCount, 0);
      checkOutput("rst_busy", busy, 0);

      // Single PRD command through the full handshake
      applyStimulus(1, 100, 32'h0001_2340, 0, 0, 0, 0);
      checkOutput("d1_count", fifoCount, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("d1_stage", outStage, 1);
      checkOutput("d1_vlr", outVlr, 100);
      checkOutput("d1_ang", outAlphaAng, 17'h01234);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      checkOutput("d1_issue_hold", outStage, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      checkOutput("d1_release", outStage, 0);

      // Fill the FIFO while downstream stalls, then overflow once
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 32'(10 + i), $urandom, 0, 0, 0, 0);
         applyStimulus(0, 0, 0, 0, 0, 0, 0);
      end
      checkOutput("full_count", fifoCount, 4);
      checkOutput("full_nodrop", dropCnt, 0);
      applyStimulus(1, 99, 0, 0, 0, 0, 0);
      checkOutput("drop_pulse", cmdDrop, 1);
      checkOutput("drop_cnt1", dropCnt, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("drop_pulse_end", cmdDrop, 0);

      // Pop and push on the same edge while full
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      checkOutput("pp_idle", outStage, 0);
      applyStimulus(2, 0, 0, 55, 66, 0, 0);
      checkOutput("pp_count", fifoCount, 4);
      checkOutput("pp_nodrop", cmdDrop, 0);
      checkOutput("pp_dropcnt", dropCnt, 1);
      checkOutput("pp_stage", outStage, 1);
      checkOutput("pp_vlr", outVlr, 11);

      // Ordering and hold-register persistence across command types
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      applyStimulus(3, 0, 0, 7, -8, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("ord_upd", outStage, 3);
      checkOutput("ord_rk", outRk, 7);
      checkOutput("ord_phisign", outPhiAng >> 16, 1);
      applyStimulus(1, 3, 32'h0000_0050, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      checkOutput("ord_gap", outStage, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("ord_prd", outStage, 1);
      checkOutput("ord_vlr", outVlr, 3);
      checkOutput("ord_rk_keep", outRk, 7);

      // Out-of-range code, then reset in the middle of a wait
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      applyStimulus(5, 1, 2, 3, 4, 0, 0);
      checkOutput("code5_count", fifoCount, 0);
      checkOutput("code5_busy", busy, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(4, 0, 0, 21, 22, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(2, 0, 0, 31, 32, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(3, 0, 0, 41, 42, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("mid_count", fifoCount, 2);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      checkOutput("mid_rst_stage", outStage, 0);
      checkOutput("mid_rst_count", fifoCount, 0);
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_rk", outRk, 0);
      applyStimulus(1, 5, 6, 0, 0, 0, 0);
      checkOutput("post_rst_event", fifoCount, 1);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int sv;
         sv = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
         applyStimulus(sv, $urandom, $urandom, $urandom, $urandom,
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
